write_request_queue: RTL and testbench

WRITE_REQUEST_QUEUE -- requirements
Module: write_request_queue

---
 rtl/write_request_queue.sv | 143 ++++++++++++++
 tb/tb_write_request_queue.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_request_queue.sv
`default_nettype none
// ============================================================================
// Module   : write_request_queue
// Purpose  : FIFO of narrow write requests, widened to output-word lanes;
//            define WRITE_REQUEST_QUEUE_COALESCE_EN to merge writes into the tail.
// Revision : 1.0 - initial release
// ============================================================================
module write_request_queue #(
    parameter int IN_ADDR_WIDTH  = 17,
    parameter int IN_DATA_WIDTH  = 16,
    parameter int OUT_DATA_WIDTH = 64,
    parameter int OUT_ADDR_WIDTH = 32,
    parameter int DEPTH          = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          io_enable,
    input  logic                          io_in_wr,
    input  logic [IN_ADDR_WIDTH-1:0]      io_in_addr,
    input  logic [IN_DATA_WIDTH-1:0]      io_in_din,
    input  logic [IN_DATA_WIDTH/8-1:0]    io_in_mask,
    output logic                          io_in_wait_n,
    output logic                          io_out_wr,
    output logic [OUT_ADDR_WIDTH-1:0]     io_out_addr,
    output logic [OUT_DATA_WIDTH/8-1:0]   io_out_mask,
    output logic [OUT_DATA_WIDTH-1:0]     io_out_din,
    input  logic                          io_out_wait_n,
    output logic [$clog2(DEPTH):0]        io_count
);

    localparam int c_LANES     = OUT_DATA_WIDTH / IN_DATA_WIDTH;
    localparam int c_LANE_BITS = $clog2(c_LANES);
    localparam int c_LANE_W    = (c_LANE_BITS > 0) ? c_LANE_BITS : 1;
    localparam int c_WADDR_W   = IN_ADDR_WIDTH - c_LANE_BITS;
    localparam int c_IN_BYTES  = IN_DATA_WIDTH / 8;
    localparam int c_OUT_BYTES = OUT_DATA_WIDTH / 8;
    localparam int c_OFF_BITS  = $clog2(c_OUT_BYTES);
    localparam int c_PTR_W     = $clog2(DEPTH);
    localparam int c_CNT_W     = c_PTR_W + 1;
    localparam int c_BADDR_W   = c_WADDR_W + c_OFF_BITS;

    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    logic [c_WADDR_W-1:0]      r_addr_mem [DEPTH];
    logic [OUT_DATA_WIDTH-1:0] r_data_mem [DEPTH];
    logic [c_OUT_BYTES-1:0]    r_mask_mem [DEPTH];

    logic [c_PTR_W-1:0]        r_rd_ptr;
    logic [c_PTR_W-1:0]        r_wr_ptr;
    logic [c_CNT_W-1:0]        r_count;

    logic [c_LANE_W-1:0]       w_lane;
    logic [c_WADDR_W-1:0]      w_in_waddr;
    logic [OUT_DATA_WIDTH-1:0] w_in_data;
    logic [c_OUT_BYTES-1:0]    w_in_mask;
    logic [c_BADDR_W-1:0]      w_head_baddr;
    logic                      w_not_empty;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_merge;
    logic                      w_alloc;

    generate
        if (c_LANE_BITS > 0) begin : g_lane
            assign w_lane = io_in_addr[c_LANE_BITS-1:0];
        end else begin : g_no_lane
            assign w_lane = '0;
        end
    endgenerate

    assign w_in_waddr = io_in_addr[IN_ADDR_WIDTH-1:c_LANE_BITS];
    assign w_in_data  = OUT_DATA_WIDTH'(io_in_din) << (w_lane * IN_DATA_WIDTH);
    assign w_in_mask  = c_OUT_BYTES'(io_in_mask) << (w_lane * c_IN_BYTES);

    assign w_not_empty  = (r_count != '0);
    assign io_in_wait_n = (r_count != c_FULL);
    assign io_out_wr    = io_enable && w_not_empty;
    assign w_push       = io_in_wr && io_in_wait_n;
    assign w_pop        = io_out_wr && io_out_wait_n;

`ifdef WRITE_REQUEST_QUEUE_COALESCE_EN
    logic [c_PTR_W-1:0]        w_tail;
    logic [OUT_DATA_WIDTH-1:0] w_in_bitmask;

    assign w_tail = r_wr_ptr - c_PTR_ONE;

    // The head may be mid-handoff downstream, so only a non-head tail merges.
    assign w_merge = w_push && (r_count >= c_CNT_W'(2))
                     && (r_addr_mem[w_tail] == w_in_waddr);

    always_comb begin
        w_in_bitmask = '0;
        for (int b = 0; b < c_OUT_BYTES; b++) begin
            w_in_bitmask[b*8 +: 8] = {8{w_in_mask[b]}};
        end
    end
`else
    assign w_merge = 1'b0;
`endif

    assign w_alloc = w_push && !w_merge;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_alloc) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= r_count + c_CNT_W'(w_alloc) - c_CNT_W'(w_pop);
        end
    end

    // Storage is deliberately unreset; the pointers alone define validity.
    always_ff @(posedge clock) begin
        if (w_alloc) begin
            r_addr_mem[r_wr_ptr] <= w_in_waddr;
            r_data_mem[r_wr_ptr] <= w_in_data;
            r_mask_mem[r_wr_ptr] <= w_in_mask;
        end
`ifdef WRITE_REQUEST_QUEUE_COALESCE_EN
        if (w_merge) begin
            r_data_mem[w_tail] <= (r_data_mem[w_tail] & ~w_in_bitmask)
                                | (w_in_data & w_in_bitmask);
            r_mask_mem[w_tail] <= r_mask_mem[w_tail] | w_in_mask;
        end
`endif
    end

    assign w_head_baddr = {r_addr_mem[r_rd_ptr], {c_OFF_BITS{1'b0}}};
    assign io_out_addr  = OUT_ADDR_WIDTH'(w_head_baddr);
    assign io_out_din   = r_data_mem[r_rd_ptr];
    assign io_out_mask  = w_not_empty ? r_mask_mem[r_rd_ptr] : '0;
    assign io_count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_write_request_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_write_request_queue
// Purpose  : Self-checking bench: vector table, corner sequences, random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_write_request_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_enable;
    logic        io_in_wr;
    logic [16:0] io_in_addr;
    logic [15:0] io_in_din;
    logic [1:0]  io_in_mask;
    logic        io_in_wait_n;
    logic        io_out_wr;
    logic [31:0] io_out_addr;
    logic [7:0]  io_out_mask;
    logic [63:0] io_out_din;
    logic        io_out_wait_n;
    logic [3:0]  io_count;

    write_request_queue #(
        .IN_ADDR_WIDTH (17),
        .IN_DATA_WIDTH (16),
        .OUT_DATA_WIDTH(64),
        .OUT_ADDR_WIDTH(32),
        .DEPTH         (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .io_enable    (io_enable),
        .io_in_wr     (io_in_wr),
        .io_in_addr   (io_in_addr),
        .io_in_din    (io_in_din),
        .io_in_mask   (io_in_mask),
        .io_in_wait_n (io_in_wait_n),
        .io_out_wr    (io_out_wr),
        .io_out_addr  (io_out_addr),
        .io_out_mask  (io_out_mask),
        .io_out_din   (io_out_din),
        .io_out_wait_n(io_out_wait_n),
        .io_count     (io_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [14:0] waddr;
        logic [63:0] data;
        logic [7:0]  mask;
    } ent_t;

    typedef struct {
        bit          wr;
        logic [16:0] addr;
        logic [15:0] din;
        logic [1:0]  mask;
        bit          ow;
        int          cnt;
        bit          wn;
        bit          owr;
        logic [7:0]  om;
        logic [31:0] oa;
        bit          chk_din;
        logic [15:0] din_hi;
    } vec_t;

    ent_t  q[$];
    vec_t  tbl[16];
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    model_on = 1'b0;

    logic [3:0]  s_count;
    logic        s_wait_n;
    logic        s_out_wr;
    logic [7:0]  s_out_mask;
    logic [31:0] s_out_addr;
    logic [63:0] s_out_din;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] expand(input logic [7:0] m);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[b*8 +: 8] = {8{m[b]}};
        return r;
    endfunction

    // One clock cycle: drive, sample/check at negedge, advance model at posedge.
    task automatic step(input bit rst, input bit wr, input logic [16:0] addr,
                        input logic [15:0] din, input logic [1:0] mask,
                        input bit en, input bit ow);
        bit   push, pop, merge;
        int   lane;
        logic [14:0] wa;
        logic [63:0] nd;
        logic [7:0]  nm;
        ent_t e;
        reset = rst; io_in_wr = wr; io_in_addr = addr; io_in_din = din;
        io_in_mask = mask; io_enable = en; io_out_wait_n = ow;
        @(negedge clock);
        s_count = io_count; s_wait_n = io_in_wait_n; s_out_wr = io_out_wr;
        s_out_mask = io_out_mask; s_out_addr = io_out_addr; s_out_din = io_out_din;
        if (model_on) begin
            chk("m_count", 64'(io_count), 64'(q.size()));
            chk("m_in_wait_n", 64'(io_in_wait_n), 64'(q.size() < 8));
            chk("m_out_wr", 64'(io_out_wr), 64'(en && q.size() != 0));
            if (q.size() != 0) begin
                chk("m_out_mask", 64'(io_out_mask), 64'(q[0].mask));
                chk("m_out_addr", 64'(io_out_addr), 64'(q[0].waddr) * 8);
                chk("m_out_din", io_out_din & expand(q[0].mask), q[0].data & expand(q[0].mask));
            end else begin
                chk("m_out_mask_empty", 64'(io_out_mask), 64'h0);
            end
        end
        @(posedge clock);
        if (rst) begin
            q.delete();
        end else begin
            push  = wr && (q.size() < 8);
            pop   = en && (q.size() > 0) && ow;
            lane  = int'(addr % 17'd4);
            wa    = 15'(addr / 17'd4);
            nd    = 64'(din) << (16 * lane);
            nm    = 8'(mask) << (2 * lane);
            merge = 1'b0;
`ifdef WRITE_REQUEST_QUEUE_COALESCE_EN
            if (push && q.size() >= 2 && q[q.size()-1].waddr == wa) merge = 1'b1;
`endif
            if (pop) void'(q.pop_front());
            if (merge) begin
                e = q[q.size()-1];
                for (int b = 0; b < 8; b++) if (nm[b]) e.data[b*8 +: 8] = nd[b*8 +: 8];
                e.mask = e.mask | nm;
                q[q.size()-1] = e;
            end else if (push) begin
                e.waddr = wa; e.data = nd; e.mask = nm;
                q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle(input bit ow);
        step(1'b0, 1'b0, 17'h0, 16'h0, 2'b00, 1'b1, ow);
    endtask

    initial begin
        logic [31:0] drain_addr [8];
        int expect_cnt;

        // Table: one row per cycle, expectations are the pre-edge outputs.
        tbl[0] = '{1, 17'h5, 16'hABCD, 2'b11, 0, 0, 1, 0, 8'h00, 32'h0, 0, 16'h0};
        tbl[1] = '{0, 17'h0, 16'h0, 2'b00, 0, 1, 1, 1, 8'h0C, 32'h8, 1, 16'hABCD};
        tbl[2] = '{0, 17'h0, 16'h0, 2'b00, 1, 1, 1, 1, 8'h0C, 32'h8, 0, 16'h0};
        for (int i = 0; i < 8; i++) begin
            tbl[3+i] = '{1, 17'(32'h100 + 4*i), 16'(32'h1000 + i), 2'b11, 0,
                         i, 1, (i > 0), (i > 0) ? 8'h03 : 8'h00, 32'h200, 0, 16'h0};
        end
        tbl[11] = '{1, 17'h400, 16'hDEAD, 2'b11, 0, 8, 0, 1, 8'h03, 32'h200, 0, 16'h0};
        tbl[12] = '{0, 17'h0,   16'h0,    2'b00, 0, 8, 0, 1, 8'h03, 32'h200, 0, 16'h0};
        tbl[13] = '{1, 17'h500, 16'hBEEF, 2'b11, 1, 8, 0, 1, 8'h03, 32'h200, 0, 16'h0};
        tbl[14] = '{1, 17'h500, 16'hBEEF, 2'b11, 0, 7, 1, 1, 8'h03, 32'h208, 0, 16'h0};
        tbl[15] = '{0, 17'h0,   16'h0,    2'b00, 0, 8, 0, 1, 8'h03, 32'h208, 0, 16'h0};

        step(1'b1, 1'b0, 17'h0, 16'h0, 2'b00, 1'b0, 1'b0);
        step(1'b1, 1'b1, 17'h0, 16'h0, 2'b11, 1'b1, 1'b1);
        model_on = 1'b1;

        for (int k = 0; k < 16; k++) begin
            step(1'b0, tbl[k].wr, tbl[k].addr, tbl[k].din, tbl[k].mask, 1'b1, tbl[k].ow);
            chk($sformatf("tbl%0d_count", k), 64'(s_count), 64'(tbl[k].cnt));
            chk($sformatf("tbl%0d_wait_n", k), 64'(s_wait_n), 64'(tbl[k].wn));
            chk($sformatf("tbl%0d_out_wr", k), 64'(s_out_wr), 64'(tbl[k].owr));
            chk($sformatf("tbl%0d_out_mask", k), 64'(s_out_mask), 64'(tbl[k].om));
            if (tbl[k].owr) chk($sformatf("tbl%0d_out_addr", k), 64'(s_out_addr), 64'(tbl[k].oa));
            if (tbl[k].chk_din) chk($sformatf("tbl%0d_din_hi", k), 64'(s_out_din[31:16]), 64'(tbl[k].din_hi));
        end

        // Drain the full queue: survivors of the first fill, then the late write.
        for (int i = 0; i < 7; i++) drain_addr[i] = 32'h208 + 32'(8*i);
        drain_addr[7] = 32'hA00;
        for (int i = 0; i < 8; i++) begin
            idle(1'b1);
            chk($sformatf("drain%0d_addr", i), 64'(s_out_addr), 64'(drain_addr[i]));
        end
        idle(1'b0);
        chk("drain_count", 64'(s_count), 64'h0);

        // Enable low holds three entries in place, then pops resume in order.
        step(1'b0, 1'b1, 17'h40, 16'h1111, 2'b11, 1'b0, 1'b1);
        step(1'b0, 1'b1, 17'h44, 16'h2222, 2'b11, 1'b0, 1'b1);
        step(1'b0, 1'b1, 17'h48, 16'h3333, 2'b11, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 17'h0, 16'h0, 2'b00, 1'b0, 1'b1);
            chk("hold_out_wr", 64'(s_out_wr), 64'h0);
            chk("hold_count", 64'(s_count), 64'd3);
        end
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            chk("resume_addr", 64'(s_out_addr), 64'(32'h80 + 32'(8*i)));
        end

        // Coalescing into a non-head tail entry.
        step(1'b0, 1'b1, 17'h10, 16'hAAAA, 2'b11, 1'b1, 1'b0);
        step(1'b0, 1'b1, 17'h20, 16'hBBBB, 2'b11, 1'b1, 1'b0);
        step(1'b0, 1'b1, 17'h21, 16'hCCCC, 2'b01, 1'b1, 1'b0);
        idle(1'b0);
`ifdef WRITE_REQUEST_QUEUE_COALESCE_EN
        expect_cnt = 2;
`else
        expect_cnt = 3;
`endif
        chk("coal_count", 64'(s_count), 64'(expect_cnt));
        idle(1'b1);
        chk("coal_head_addr", 64'(s_out_addr), 64'h20);
        idle(1'b1);
        chk("coal_second_addr", 64'(s_out_addr), 64'h40);
`ifdef WRITE_REQUEST_QUEUE_COALESCE_EN
        chk("coal_second_mask", 64'(s_out_mask), 64'h07);
`else
        chk("coal_second_mask", 64'(s_out_mask), 64'h03);
`endif
        idle(1'b1);
        idle(1'b1);

        // Reset beats a concurrent write with four entries queued.
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 17'(32'h200 + 16*i), 16'h5A5A, 2'b11, 1'b1, 1'b0);
        step(1'b1, 1'b1, 17'h300, 16'h1234, 2'b11, 1'b1, 1'b0);
        idle(1'b0);
        chk("rst_count", 64'(s_count), 64'h0);
        chk("rst_out_wr", 64'(s_out_wr), 64'h0);
        chk("rst_out_mask", 64'(s_out_mask), 64'h0);
        chk("rst_wait_n", 64'(s_wait_n), 64'h1);

        // Random traffic against the queue model; narrow address range forces tail hits.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 9) < 7),
                 17'($urandom_range(0, 15)),
                 16'($urandom),
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 9) < 5));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
